// File: rtl/bldc_commutator.sv
// Six-step hall commutator: synchronises and filters the hall code, slew-limits the duty,
// and drives duty/high_z for the three phase drivers, including brake, reversal and hall-fault handling.
module bldc_commutator #(
  parameter int unsigned DUTY_W    = 9,
  parameter int unsigned HALL_FILT = 4,
  parameter int unsigned RAMP_STEP = 8,
  parameter int unsigned RAMP_DIV  = 16,
  parameter int unsigned FAULT_LIM = 3
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              enable,
  input  logic              brake,
  input  logic              direction,
  input  logic [DUTY_W-1:0] duty_cmd,
  input  logic [2:0]        hall,
  output logic [DUTY_W-1:0] phase_duty_a,
  output logic [DUTY_W-1:0] phase_duty_b,
  output logic [DUTY_W-1:0] phase_duty_c,
  output logic              high_z_a,
  output logic              high_z_b,
  output logic              high_z_c,
  output logic              hall_fault,
  output logic [15:0]       hall_edges
);

  localparam int unsigned FILT_W = $clog2(HALL_FILT + 1);
  localparam int unsigned DIV_W  = $clog2(RAMP_DIV + 1);
  localparam int unsigned FCNT_W = $clog2(FAULT_LIM + 1);
  localparam int unsigned EXT_W  = DUTY_W + 1;

  localparam logic [1:0] PH_A    = 2'd0;
  localparam logic [1:0] PH_B    = 2'd1;
  localparam logic [1:0] PH_C    = 2'd2;
  localparam logic [1:0] PH_NONE = 2'd3;

  logic [2:0]        hall_s1, hall_s2, hall_acc;
  logic [FILT_W-1:0] filt_cnt;
  logic [FCNT_W-1:0] fault_cnt;
  logic [DIV_W-1:0]  div_cnt;
  logic [DUTY_W-1:0] duty_ramp;
  logic              dir_lat;
  logic [DUTY_W-1:0] duty_q [3];
  logic              hz_q [3];

  logic              accept_c, new_code_c, new_valid_c, acc_valid_c, tick_c;
  logic [DUTY_W-1:0] target_c, ramp_next_c;
  logic [EXT_W-1:0]  ramp_ext_c, tgt_ext_c, step_ext_c, diff_c, sum_c;
  logic [1:0]        fwd_hi_c, fwd_lo_c, hi_c, lo_c;

  // Acceptance, ramp step and commutation decode
  always_comb begin
    accept_c    = (hall_s1 == hall_s2) && (filt_cnt == FILT_W'(HALL_FILT - 1));
    new_code_c  = accept_c && (hall_s2 != hall_acc);
    new_valid_c = (hall_s2 != 3'b000) && (hall_s2 != 3'b111);
    acc_valid_c = (hall_acc != 3'b000) && (hall_acc != 3'b111);
    tick_c      = (div_cnt == DIV_W'(RAMP_DIV - 1));

    // A pending reversal pulls the ramp to zero before the new direction is latched
    target_c   = (direction != dir_lat) ? '0 : duty_cmd;
    ramp_ext_c = EXT_W'(duty_ramp);
    tgt_ext_c  = EXT_W'(target_c);
    step_ext_c = EXT_W'(RAMP_STEP);
    if (tgt_ext_c > ramp_ext_c) begin
      diff_c = tgt_ext_c - ramp_ext_c;
      sum_c  = ramp_ext_c + ((diff_c < step_ext_c) ? diff_c : step_ext_c);
    end else begin
      diff_c = ramp_ext_c - tgt_ext_c;
      sum_c  = ramp_ext_c - ((diff_c < step_ext_c) ? diff_c : step_ext_c);
    end
    ramp_next_c = DUTY_W'(sum_c);

    fwd_hi_c = PH_NONE;
    fwd_lo_c = PH_NONE;
    case (hall_acc)
      3'b101:  begin fwd_hi_c = PH_A; fwd_lo_c = PH_B; end
      3'b100:  begin fwd_hi_c = PH_A; fwd_lo_c = PH_C; end
      3'b110:  begin fwd_hi_c = PH_B; fwd_lo_c = PH_C; end
      3'b010:  begin fwd_hi_c = PH_B; fwd_lo_c = PH_A; end
      3'b011:  begin fwd_hi_c = PH_C; fwd_lo_c = PH_A; end
      3'b001:  begin fwd_hi_c = PH_C; fwd_lo_c = PH_B; end
      default: begin fwd_hi_c = PH_NONE; fwd_lo_c = PH_NONE; end
    endcase
    hi_c = dir_lat ? fwd_lo_c : fwd_hi_c;
    lo_c = dir_lat ? fwd_hi_c : fwd_lo_c;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      hall_s1    <= 3'b000;
      hall_s2    <= 3'b000;
      hall_acc   <= 3'b000;
      filt_cnt   <= '0;
      fault_cnt  <= '0;
      hall_fault <= 1'b0;
      hall_edges <= 16'd0;
      div_cnt    <= '0;
      duty_ramp  <= '0;
      dir_lat    <= 1'b0;
      for (int p = 0; p < 3; p++) begin
        duty_q[p] <= '0;
        hz_q[p]   <= 1'b1;
      end
    end else begin
      hall_s1 <= hall;
      hall_s2 <= hall_s1;
      if (hall_s1 != hall_s2)
        filt_cnt <= '0;
      else if (filt_cnt != FILT_W'(HALL_FILT))
        filt_cnt <= filt_cnt + FILT_W'(1);

      if (accept_c)
        hall_acc <= hall_s2;
      if (new_code_c && new_valid_c)
        hall_edges <= hall_edges + 16'd1;

      // Fault count saturates at the limit; disabling clears the sticky flag
      if (!enable) begin
        fault_cnt  <= '0;
        hall_fault <= 1'b0;
      end else if (new_code_c && !new_valid_c && (fault_cnt != FCNT_W'(FAULT_LIM))) begin
        fault_cnt <= fault_cnt + FCNT_W'(1);
        if (fault_cnt == FCNT_W'(FAULT_LIM - 1))
          hall_fault <= 1'b1;
      end

      div_cnt <= tick_c ? '0 : div_cnt + DIV_W'(1);
      if (!enable || hall_fault)
        duty_ramp <= '0;
      else if (!brake && tick_c)
        duty_ramp <= ramp_next_c;

      if (duty_ramp == '0)
        dir_lat <= direction;

      for (int p = 0; p < 3; p++) begin
        if (!enable || hall_fault) begin
          duty_q[p] <= '0;
          hz_q[p]   <= 1'b1;
        end else if (brake) begin
          duty_q[p] <= '0;
          hz_q[p]   <= 1'b0;
        end else if (!acc_valid_c) begin
          duty_q[p] <= '0;
          hz_q[p]   <= 1'b1;
        end else if (2'(p) == hi_c) begin
          duty_q[p] <= duty_ramp;
          hz_q[p]   <= 1'b0;
        end else if (2'(p) == lo_c) begin
          duty_q[p] <= '0;
          hz_q[p]   <= 1'b0;
        end else begin
          duty_q[p] <= '0;
          hz_q[p]   <= 1'b1;
        end
      end
    end
  end

  assign phase_duty_a = duty_q[0];
  assign phase_duty_b = duty_q[1];
  assign phase_duty_c = duty_q[2];
  assign high_z_a     = hz_q[0];
  assign high_z_b     = hz_q[1];
  assign high_z_c     = hz_q[2];

endmodule
